mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single instruction/data memory port between the I-cache refill controller and the D-cache controller.
- Grants the port to one requester at a time and sequences either a 4-word line read (burst) or a single-word access.
- Returns read data beat by beat and signals completion.
- Sits between both cache controllers and the memory wrapper, replacing direct controller-to-memory wiring.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data word width.
- BEATS, 4, words per cache line (power of 2); beat counter width is log2(BEATS).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_req  in  1  I-side request, held until i_done
- i_addr  in  ADDR_W  I-side miss address
- i_gnt  out  1  I-side owns port
- i_rvalid  out  1  I-side read beat valid
- i_rdata  out  DATA_W  I-side read data
- i_beat  out  log2(BEATS)  index of current I beat
- i_done  out  1  I transaction complete (1-cycle pulse)
- d_req  in  1  D-side request, held until d_done
- d_we  in  1  D-side write (single word)
- d_burst  in  1  D-side line read (ignored when d_we=1)
- d_addr  in  ADDR_W  D-side address
- d_wdata  in  DATA_W  D-side write data
- d_gnt, d_rvalid, d_rdata, d_beat, d_done  out  as I-side
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory completes current beat this cycle

Behaviour:
- State register cstate: IDLE, SERVE_I, SERVE_D. Registers: beat counter cnt, last_owner (0=I, 1=D), is_burst.
- Reset: cstate=IDLE, cnt=0, last_owner=1 (I wins first tie). All outputs are 0.
- IDLE:
  - Only i_req -> SERVE_I.
  - Only d_req -> SERVE_D.
  - Both -> the side that is not last_owner.
  - Neither -> stay.
  - The grant decision is registered; no memory activity occurs in IDLE.
- On entry to SERVE_x: latch is_burst (1 for I; d_burst & ~d_we for D). Latch last_owner on entry.
- SERVE_x outputs (combinational from state):
  - x_gnt=1, mem_en=1.
  - mem_we = d_we in SERVE_D, else 0.
  - mem_wdata = d_wdata in SERVE_D, else 0.
  - Burst: mem_addr = {addr[ADDR_W-1:log2(BEATS)+2], cnt, 2'b00}. Single: mem_addr = addr unmodified.
  - x_beat = cnt.
- Beat completion: mem_ready high in SERVE_x.
  - Read: x_rvalid=1, x_rdata=mem_rdata in the same cycle.
  - Writes give no rvalid.
  - cnt increments.
- Last beat: cnt==BEATS-1 for burst; the first beat for single.
  - With mem_ready: x_done=1 that cycle; cnt <- 0; next state IDLE.
  - At least one IDLE cycle separates transactions (arbitration bubble).
- mem_ready low: hold address and cnt, no rvalid.
- Non-owner outputs (gnt, rvalid, done) are 0. Rdata for non-owner is 0.
- Requests are sampled only in IDLE. Dropping req mid-transaction is illegal; the arbiter completes the access regardless.
- A request asserted in the same cycle as the other side's done is served after the bubble, per round-robin.
- rst mid-transaction aborts immediately: IDLE, cnt=0, outputs 0. No done is issued.
- Counter wrap: cnt is log2(BEATS) bits. It is cleared on done and never wraps otherwise.

Decomposition:
- Shared package mem_arb_pkg: state enum (IDLE/SERVE_I/SERVE_D), owner constants, BEATS default, offset-width localparam.
- One natural sub-module: mem_arb_rr, the 2-way round-robin picker (req_i, req_d, last_owner -> pick). The rest stays flat.

Test Plan:
- I line refill, i_addr=0x0000_1238, mem_ready=1 constant:
  - i_req at cycle 0 -> i_gnt cycles 1-4.
  - mem_addr 0x1230, 0x1234, 0x1238, 0x123C.
  - i_rvalid each cycle, i_done at cycle 4.
  - IDLE at cycle 5.
- Same refill with mem_ready low on cycles 2-3:
  - mem_addr holds 0x1234, i_beat=1 holds.
  - i_done moves to cycle 6.
  - Exactly 4 rvalid pulses.
- i_req and d_req both high at cycle 0 after reset:
  - I served first.
  - D (d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF) granted after the bubble.
  - mem_we=1 for one beat, d_done with no d_rvalid.
- Continuous i_req and d_req: grants alternate I, D, I, D with one IDLE cycle between each.
- D burst read d_addr=0x40 returning data 0xA0..0xA3: d_rdata and d_beat match per beat; i_* outputs stay 0.
- rst asserted at beat 2 of an I burst:
  - Outputs 0 asynchronously; no i_done.
  - After release, a new i_req restarts at beat 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam int BEATS_DEF = 4;
  localparam int OFF_W     = $clog2(BEATS_DEF);

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signal bundle
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS  = BEATS_DEF
);
  localparam int CNT_W = $clog2(BEATS);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic [CNT_W-1:0]  i_beat;
  logic              i_done;

  logic              d_req;
  logic              d_we;
  logic              d_burst;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic [CNT_W-1:0]  d_beat;
  logic              d_done;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  // Arbiter side
  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata, i_beat, i_done,
    input  d_req, d_we, d_burst, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata, d_beat, d_done,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  // Cache controllers plus memory wrapper side
  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata, i_beat, i_done,
    output d_req, d_we, d_burst, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata, d_beat, d_done,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - two-way round-robin picker between I and D requesters
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_owner,
  output logic pick_valid,
  output logic pick_d
);

  // On a tie the side that did not own the port last time wins
  assign pick_valid = req_i | req_d;
  assign pick_d     = (req_i & req_d) ? (last_owner == OWNER_I) : req_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between I-cache and D-cache controllers
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS  = BEATS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(BEATS);

  state_t           cstate, nstate;
  logic [CNT_W-1:0] cnt;
  logic             last_owner;
  logic             is_burst;
  logic             pick_valid;
  logic             pick_d;
  logic             beat_ok;
  logic             last_beat;

  mem_arb_rr u_rr (
    .req_i      (bus.i_req),
    .req_d      (bus.d_req),
    .last_owner (last_owner),
    .pick_valid (pick_valid),
    .pick_d     (pick_d)
  );

  assign beat_ok   = (cstate != IDLE) & bus.mem_ready;
  assign last_beat = ~is_burst | (cnt == CNT_W'(BEATS - 1));

  // State, beat counter and grant bookkeeping; reset aborts any transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cstate     <= IDLE;
      cnt        <= '0;
      last_owner <= OWNER_D;
      is_burst   <= 1'b0;
    end else begin
      cstate <= nstate;
      if (cstate == IDLE && pick_valid) begin
        is_burst   <= pick_d ? (bus.d_burst & ~bus.d_we) : 1'b1;
        last_owner <= pick_d ? OWNER_D : OWNER_I;
      end
      if (beat_ok) begin
        cnt <= last_beat ? '0 : cnt + 1'b1;
      end
    end
  end

  // Next state and all port outputs, decoded from the current owner
  always_comb begin
    nstate        = cstate;
    bus.i_gnt     = 1'b0;
    bus.i_rvalid  = 1'b0;
    bus.i_rdata   = '0;
    bus.i_beat    = '0;
    bus.i_done    = 1'b0;
    bus.d_gnt     = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.d_rdata   = '0;
    bus.d_beat    = '0;
    bus.d_done    = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (cstate)
      IDLE: begin
        if (pick_valid) begin
          nstate = pick_d ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I: begin
        bus.i_gnt    = 1'b1;
        bus.mem_en   = 1'b1;
        bus.mem_addr = {bus.i_addr[ADDR_W-1:CNT_W+2], cnt, 2'b00};
        bus.i_beat   = cnt;
        bus.i_rdata  = bus.mem_rdata;
        bus.i_rvalid = bus.mem_ready;
        if (beat_ok && last_beat) begin
          bus.i_done = 1'b1;
          nstate     = IDLE;
        end
      end
      SERVE_D: begin
        bus.d_gnt     = 1'b1;
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.d_we;
        bus.mem_wdata = bus.d_wdata;
        bus.mem_addr  = is_burst ? {bus.d_addr[ADDR_W-1:CNT_W+2], cnt, 2'b00} : bus.d_addr;
        bus.d_beat    = cnt;
        bus.d_rdata   = bus.mem_rdata;
        bus.d_rvalid  = bus.mem_ready & ~bus.d_we;
        if (beat_ok && last_beat) begin
          bus.d_done = 1'b1;
          nstate     = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BEATS  = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Transaction-level reference: owner 0=none 1=I 2=D, beats done / beats needed
  int m_owner = 0;
  int m_beat  = 0;
  int m_total = 0;
  int m_last  = 2;
  bit i_fin, d_fin;
  bit i_out, d_out;
  int i_rv_n, d_rv_n, we_n;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] line_addr(input logic [31:0] a, input int beat);
    int unsigned line_bytes;
    line_bytes = BEATS * 4;
    return a - (a % line_bytes) + 4 * beat;
  endfunction

  task automatic compare_outputs();
    logic own_i, own_d, e_en, e_we, e_irv, e_drv, e_idn, e_ddn, is_last;
    logic [31:0] e_addr, e_wdata;
    logic [1:0]  e_ib, e_db;
    own_i   = !rst && m_owner == 1;
    own_d   = !rst && m_owner == 2;
    is_last = (m_beat == m_total - 1);
    e_en    = own_i | own_d;
    e_we    = own_d & bus.d_we;
    e_wdata = own_d ? bus.d_wdata : 32'h0;
    if (own_i)      e_addr = line_addr(bus.i_addr, m_beat);
    else if (own_d) e_addr = (m_total == BEATS) ? line_addr(bus.d_addr, m_beat) : bus.d_addr;
    else            e_addr = 32'h0;
    e_irv = own_i & bus.mem_ready;
    e_drv = own_d & bus.mem_ready & ~bus.d_we;
    e_idn = own_i & bus.mem_ready & is_last;
    e_ddn = own_d & bus.mem_ready & is_last;
    e_ib  = own_i ? 2'(m_beat) : 2'd0;
    e_db  = own_d ? 2'(m_beat) : 2'd0;
    check("i_gnt",     bus.i_gnt,     own_i);
    check("d_gnt",     bus.d_gnt,     own_d);
    check("mem_en",    bus.mem_en,    e_en);
    check("mem_we",    bus.mem_we,    e_we);
    check("mem_addr",  bus.mem_addr,  e_addr);
    check("mem_wdata", bus.mem_wdata, e_wdata);
    check("i_rvalid",  bus.i_rvalid,  e_irv);
    check("d_rvalid",  bus.d_rvalid,  e_drv);
    check("i_done",    bus.i_done,    e_idn);
    check("d_done",    bus.d_done,    e_ddn);
    check("i_beat",    bus.i_beat,    e_ib);
    check("d_beat",    bus.d_beat,    e_db);
    if (e_irv || !own_i) check("i_rdata", bus.i_rdata, own_i ? bus.mem_rdata : 32'h0);
    if (e_drv || !own_d) check("d_rdata", bus.d_rdata, own_d ? bus.mem_rdata : 32'h0);
    if (bus.i_rvalid) i_rv_n++;
    if (bus.d_rvalid) d_rv_n++;
    if (bus.mem_we)   we_n++;
  endtask

  task automatic advance();
    int win;
    i_fin = 0;
    d_fin = 0;
    if (rst) begin
      m_owner = 0;
      m_beat  = 0;
      m_last  = 2;
    end else if (m_owner == 0) begin
      if (bus.i_req || bus.d_req) begin
        if (bus.i_req && bus.d_req) win = (m_last == 1) ? 2 : 1;
        else                        win = bus.i_req ? 1 : 2;
        m_owner = win;
        m_beat  = 0;
        m_last  = win;
        if (win == 1)        m_total = BEATS;
        else if (bus.d_we)   m_total = 1;
        else                 m_total = bus.d_burst ? BEATS : 1;
      end
    end else if (bus.mem_ready) begin
      m_beat++;
      if (m_beat == m_total) begin
        if (m_owner == 1) i_fin = 1;
        else              d_fin = 1;
        m_owner = 0;
        m_beat  = 0;
      end
    end
  endtask

  // Called at a falling edge with this cycle's inputs already driven
  task automatic run_cycle();
    #1;
    compare_outputs();
    advance();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    run_cycle();
    run_cycle();
    rst = 1'b0;
  endtask

  task automatic i_refill(input bit stall, output int lat);
    lat = 0;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_1238;
    i_rv_n = 0;
    for (int k = 0; k < 20; k++) begin
      bus.mem_ready = !(stall && (k == 2 || k == 3));
      bus.mem_rdata = $urandom;
      lat++;
      run_cycle();
      if (i_fin) break;
    end
    bus.i_req = 1'b0;
    bus.mem_ready = 1'b1;
  endtask

  initial begin
    int lat;
    int first;
    bit i_seen, d_seen;
    rst           = 1'b1;
    bus.i_req     = 1'b0;
    bus.i_addr    = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_burst   = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    do_reset();

    i_refill(1'b0, lat);
    check("i_refill_lat", lat, 5);
    check("i_refill_rv", i_rv_n, 4);
    run_cycle();

    i_refill(1'b1, lat);
    check("i_stall_lat", lat, 7);
    check("i_stall_rv", i_rv_n, 4);
    run_cycle();

    do_reset();
    bus.i_req   = 1'b1;
    bus.i_addr  = 32'h0000_0100;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h0000_2004;
    bus.d_wdata = 32'hDEAD_BEEF;
    first = 0; i_seen = 0; d_seen = 0;
    we_n = 0; d_rv_n = 0;
    for (int k = 0; k < 30 && !(i_seen && d_seen); k++) begin
      bus.mem_rdata = $urandom;
      run_cycle();
      if (i_fin) begin i_seen = 1; bus.i_req = 1'b0; if (first == 0) first = 1; end
      if (d_fin) begin d_seen = 1; bus.d_req = 1'b0; if (first == 0) first = 2; end
    end
    check("tie_first_i", first, 1);
    check("tie_both_done", {i_seen, d_seen}, 2'b11);
    check("d_write_we_beats", we_n, 1);
    check("d_write_no_rv", d_rv_n, 0);
    run_cycle();

    i_out = 0;
    d_out = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst = ($urandom_range(299) == 0);
      if (!i_out) begin
        if ($urandom_range(3) != 0) begin
          bus.i_req  = 1'b1;
          bus.i_addr = $urandom;
          i_out = 1;
        end else begin
          bus.i_req = 1'b0;
        end
      end
      if (!d_out) begin
        if ($urandom_range(3) != 0) begin
          bus.d_req   = 1'b1;
          bus.d_we    = $urandom_range(1);
          bus.d_burst = $urandom_range(1);
          bus.d_addr  = $urandom;
          bus.d_wdata = $urandom;
          d_out = 1;
        end else begin
          bus.d_req = 1'b0;
        end
      end
      bus.mem_ready = ($urandom_range(3) != 0);
      bus.mem_rdata = $urandom;
      run_cycle();
      if (i_fin || rst) i_out = 0;
      if (d_fin || rst) d_out = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
